// File: rtl/l298n_pwm_multi.sv
// N-channel L298N H-bridge PWM controller on an Avalon-MM slave: shared period
// counter, per-channel duty ramp, brake and dead-time interlock on polarity change.
module l298n_pwm_multi #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16,
  parameter int DEADTIME = 50
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm_en,
  output logic [NUM_CH-1:0] pwm_in_a,
  output logic [NUM_CH-1:0] pwm_in_b
);

  // The load cycle itself counts as the first coast cycle, so the counter holds DEADTIME-1.
  localparam int DT_W = (DEADTIME >= 2) ? $clog2(DEADTIME) : 1;
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

  typedef enum logic [1:0] {KEY_NONE, KEY_FWD, KEY_REV, KEY_BRAKE} key_t;

  logic [1:0]                   rst_sync;
  logic                         rst_n;
  logic [CNT_W-1:0]             period, per_act, cnt;
  logic [NUM_CH-1:0][2:0]       ctrl;
  logic [NUM_CH-1:0][CNT_W-1:0] duty, ramp, cur_duty;
  logic [NUM_CH-1:0][DT_W-1:0]  dt_cnt;
  key_t                         req_key  [NUM_CH];
  key_t                         prev_key [NUM_CH];
  logic [NUM_CH-1:0]            dt_load, dead, pwm;
  logic                         wrap;
  logic [31:0]                  rd_mux;
  logic                         wr_unused;

  assign wr_unused = ^avs_writedata;

  function automatic logic [CNT_W-1:0] ramp_step(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt,
                                                 input logic [CNT_W-1:0] step);
    logic [CNT_W-1:0] diff;
    if (step == '0) return tgt;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (step < diff) ? cur + step : tgt;
    end
    diff = cur - tgt;
    return (step < diff) ? cur - step : tgt;
  endfunction

  // Asynchronous assertion, synchronised release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
      ctrl   <= '0;
      duty   <= '0;
      ramp   <= '0;
    end else if (avs_write) begin
      if (avs_address == 8'h00) period <= avs_writedata[CNT_W-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (avs_address == 8'(4*c + 4)) ctrl[c] <= avs_writedata[2:0];
        if (avs_address == 8'(4*c + 5)) duty[c] <= avs_writedata[CNT_W-1:0];
        if (avs_address == 8'(4*c + 6)) ramp[c] <= avs_writedata[CNT_W-1:0];
      end
    end
  end

  assign wrap = (per_act != '0) && (cnt == per_act - CNT_W'(1));

  // Shared frame counter; a zero active period parks it and keeps polling PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_act <= '0;
      cnt     <= '0;
    end else if (per_act == '0) begin
      per_act <= period;
      cnt     <= '0;
    end else if (wrap) begin
      per_act <= period;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!ctrl[c][0])     req_key[c] = KEY_NONE;
      else if (ctrl[c][2]) req_key[c] = KEY_BRAKE;
      else if (ctrl[c][1]) req_key[c] = KEY_REV;
      else                 req_key[c] = KEY_FWD;
      dt_load[c] = (req_key[c] != prev_key[c]) && (req_key[c] != KEY_NONE)
                   && (prev_key[c] != KEY_NONE);
      dead[c]    = ctrl[c][0] && (dt_load[c] || (dt_cnt[c] != '0));
      pwm[c]     = (per_act != '0) && (cur_duty[c] > cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_duty <= '0;
      dt_cnt   <= '0;
      for (int c = 0; c < NUM_CH; c++) prev_key[c] <= KEY_NONE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        prev_key[c] <= req_key[c];
        if (!ctrl[c][0]) begin
          cur_duty[c] <= '0;
          dt_cnt[c]   <= '0;
        end else begin
          if (wrap) cur_duty[c] <= ramp_step(cur_duty[c], duty[c], ramp[c]);
          if (dt_load[c])            dt_cnt[c] <= DT_LOAD;
          else if (dt_cnt[c] != '0) dt_cnt[c] <= dt_cnt[c] - DT_W'(1);
        end
      end
    end
  end

  // Registered bridge pins: disabled > dead > brake > run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_en   <= '0;
      pwm_in_a <= '0;
      pwm_in_b <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!ctrl[c][0] || dead[c]) begin
          pwm_en[c]   <= 1'b0;
          pwm_in_a[c] <= 1'b0;
          pwm_in_b[c] <= 1'b0;
        end else if (ctrl[c][2]) begin
          pwm_en[c]   <= 1'b1;
          pwm_in_a[c] <= 1'b1;
          pwm_in_b[c] <= 1'b1;
        end else begin
          pwm_en[c]   <= pwm[c];
          pwm_in_a[c] <= ~ctrl[c][1];
          pwm_in_b[c] <= ctrl[c][1];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (avs_address == 8'h00) rd_mux[CNT_W-1:0]  = period;
    if (avs_address == 8'h01) rd_mux[NUM_CH-1:0] = dead;
    for (int c = 0; c < NUM_CH; c++) begin
      if (avs_address == 8'(4*c + 4)) rd_mux[2:0]       = ctrl[c];
      if (avs_address == 8'(4*c + 5)) rd_mux[CNT_W-1:0] = duty[c];
      if (avs_address == 8'(4*c + 6)) rd_mux[CNT_W-1:0] = ramp[c];
      if (avs_address == 8'(4*c + 7)) rd_mux[CNT_W-1:0] = cur_duty[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) avs_readdata <= '0;
    else        avs_readdata <= avs_read ? rd_mux : '0;
  end

endmodule
